// File: rtl/mux_rr_pipe.sv
// N_IN-channel valid/ready multiplexer with one registered output stage.
// Channel selection is either an external index (MODE 0) or round-robin arbitration (MODE 1).
module mux_rr_pipe #(
    parameter int WIDTH = 32,
    parameter int N_IN  = 4,
    parameter int MODE  = 0,
    localparam int SW   = (N_IN > 1) ? $clog2(N_IN) : 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [N_IN-1:0]         in_valid,
    input  logic [N_IN*WIDTH-1:0]   in_data,
    output logic [N_IN-1:0]         in_ready,
    input  logic [SW-1:0]           sel,
    output logic                    out_valid,
    output logic [WIDTH-1:0]        out_data,
    output logic [SW-1:0]           out_ch,
    input  logic                    out_ready
);

    logic             load_en;
    logic             hit;
    logic             transfer;
    logic [SW-1:0]    g;
    logic [SW-1:0]    ptr;
    logic [SW-1:0]    ptr_next;
    logic [WIDTH-1:0] grant_data;

    assign load_en = ~out_valid | out_ready;

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path leaves a value unassigned and no latch is inferred.
        hit = 1'b0;
        g   = '0;
        if (MODE == 0) begin
            // An out-of-range sel matches no channel, so nothing is granted.
            for (int i = 0; i < N_IN; i++) begin
                if (sel == SW'(i)) begin
                    hit = 1'b1;
                    g   = SW'(i);
                end
            end
        end else begin
            // Two passes: first channels at or above ptr, then wrap to the lowest valid one.
            for (int i = 0; i < N_IN; i++) begin
                if (!hit && in_valid[i] && (SW'(i) >= ptr)) begin
                    hit = 1'b1;
                    g   = SW'(i);
                end
            end
            for (int i = 0; i < N_IN; i++) begin
                if (!hit && in_valid[i]) begin
                    hit = 1'b1;
                    g   = SW'(i);
                end
            end
        end
    end

    always_comb begin
        in_ready   = '0;
        grant_data = '0;
        for (int i = 0; i < N_IN; i++) begin
            in_ready[i] = rst_n & load_en & hit & (g == SW'(i));
            if (g == SW'(i)) begin
                grant_data = in_data[i*WIDTH +: WIDTH];
            end
        end
    end

    assign transfer = |(in_valid & in_ready);
    assign ptr_next = (g == SW'(N_IN - 1)) ? '0 : g + SW'(1);

    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every register samples pre-edge values; reset is synchronous.
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_ch    <= '0;
            ptr       <= '0;
        end else if (load_en) begin
            out_valid <= transfer;
            if (transfer) begin
                out_data <= grant_data;
                out_ch   <= g;
                ptr      <= ptr_next;
            end
        end
    end

endmodule

// File: tb/tb_mux_rr_pipe.sv
// Self-checking bench for mux_rr_pipe: select mode (4 and 3 channels) and round-robin mode.
// Expected words flow through a scoreboard queue; in_ready expectations come from a vector table.
module tb_mux_rr_pipe;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [3:0]   in_valid;
    logic [127:0] in_data;
    logic [1:0]   sel;
    logic         out_ready;

    logic [3:0]   r0, r1;
    logic [2:0]   r2;
    logic         ov0, ov1, ov2;
    logic [31:0]  od0, od1, od2;
    logic [1:0]   oc0, oc1, oc2;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    mux_rr_pipe #(.WIDTH(32), .N_IN(4), .MODE(0)) u_sel4 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
        .in_ready(r0), .sel(sel), .out_valid(ov0), .out_data(od0),
        .out_ch(oc0), .out_ready(out_ready)
    );

    mux_rr_pipe #(.WIDTH(32), .N_IN(4), .MODE(1)) u_rr4 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
        .in_ready(r1), .sel(sel), .out_valid(ov1), .out_data(od1),
        .out_ch(oc1), .out_ready(out_ready)
    );

    mux_rr_pipe #(.WIDTH(32), .N_IN(3), .MODE(0)) u_sel3 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid[2:0]), .in_data(in_data[95:0]),
        .in_ready(r2), .sel(sel), .out_valid(ov2), .out_data(od2),
        .out_ch(oc2), .out_ready(out_ready)
    );

    typedef struct packed {
        logic [1:0]  ch;
        logic [31:0] data;
    } word_t;

    typedef struct {
        bit         rst;
        int         d;
        logic [3:0] v;
        logic [1:0] s;
        logic       ordy;
        logic [3:0] rdy;
    } vec_t;

    word_t q[$];
    word_t last;
    vec_t  tbl[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic sample(input int d, output logic [3:0] rdy, output logic ov,
                          output logic [31:0] od, output logic [1:0] oc);
        case (d)
            0:       begin rdy = r0;         ov = ov0; od = od0; oc = oc0; end
            1:       begin rdy = r1;         ov = ov1; od = od1; oc = oc1; end
            default: begin rdy = {1'b0, r2}; ov = ov2; od = od2; oc = oc2; end
        endcase
    endtask

    task automatic randomize_data();
        for (int i = 0; i < 4; i++) in_data[i*32 +: 32] = $urandom;
    endtask

    task automatic do_reset(input int d);
        logic [3:0] rdy; logic ov; logic [31:0] od; logic [1:0] oc;
        rst_n = 1'b0; in_valid = 4'hF; sel = 2'd2; out_ready = 1'b1;
        #1;
        sample(d, rdy, ov, od, oc);
        check("rst_in_ready", rdy, 4'h0);
        @(posedge clk); #1;
        sample(d, rdy, ov, od, oc);
        check("rst_out_valid", ov, 1'b0);
        check("rst_out_data", od, 32'h0);
        check("rst_out_ch", oc, 2'd0);
        q.delete();
        last  = '0;
        rst_n = 1'b1;
    endtask

    // One clock: drive inputs, check in_ready, update the scoreboard, then check the output register.
    task automatic cycle(input int d, input logic [3:0] v, input logic [1:0] s,
                         input logic ordy, input logic [3:0] exp_rdy);
        logic [3:0] rdy; logic ov; logic [31:0] od; logic [1:0] oc;
        logic [3:0] xfer;
        in_valid = v; sel = s; out_ready = ordy;
        #1;
        sample(d, rdy, ov, od, oc);
        check("in_ready", rdy, exp_rdy);
        if (q.size() > 0 && ordy) last = q.pop_front();
        xfer = v & exp_rdy;
        for (int i = 0; i < 4; i++) begin
            if (xfer[i]) q.push_back({2'(i), in_data[i*32 +: 32]});
        end
        @(posedge clk); #1;
        sample(d, rdy, ov, od, oc);
        check("out_valid", ov, q.size() > 0);
        if (q.size() > 0) begin
            check("out_data", od, q[0].data);
            check("out_ch", oc, q[0].ch);
        end else begin
            check("held_data", od, last.data);
            check("held_ch", oc, last.ch);
        end
    endtask

    task automatic add(input bit rst, input int d, input logic [3:0] v, input logic [1:0] s,
                       input logic ordy, input logic [3:0] rdy);
        tbl.push_back('{rst, d, v, s, ordy, rdy});
    endtask

    initial begin
        logic [3:0] rdy; logic ov; logic [31:0] od; logic [1:0] oc;

        // Select mode, 4 channels: fresh reset, then bubbles, stalls, sel changes while held.
        add(1, 0, 4'b0000, 2'd0, 1'b0, 4'b0000);
        add(0, 0, 4'b0100, 2'd2, 1'b0, 4'b0100);
        add(0, 0, 4'b0000, 2'd0, 1'b1, 4'b0001);
        add(0, 0, 4'b0010, 2'd1, 1'b0, 4'b0010);
        add(0, 0, 4'b1000, 2'd3, 1'b0, 4'b0000);
        add(0, 0, 4'b1111, 2'd0, 1'b0, 4'b0000);
        add(0, 0, 4'b1000, 2'd3, 1'b1, 4'b1000);
        add(0, 0, 4'b0111, 2'd3, 1'b1, 4'b1000);
        // Round-robin: full load gives 0,1,2,3,0,1; then only ch1/ch3 with ptr at 2.
        add(1, 1, 4'b0000, 2'd0, 1'b0, 4'b0000);
        add(0, 1, 4'b1111, 2'd0, 1'b1, 4'b0001);
        add(0, 1, 4'b1111, 2'd0, 1'b1, 4'b0010);
        add(0, 1, 4'b1111, 2'd0, 1'b1, 4'b0100);
        add(0, 1, 4'b1111, 2'd0, 1'b1, 4'b1000);
        add(0, 1, 4'b1111, 2'd0, 1'b1, 4'b0001);
        add(0, 1, 4'b1111, 2'd0, 1'b1, 4'b0010);
        add(0, 1, 4'b1010, 2'd0, 1'b1, 4'b1000);
        add(0, 1, 4'b1010, 2'd0, 1'b1, 4'b0010);
        add(0, 1, 4'b1010, 2'd0, 1'b1, 4'b1000);
        add(0, 1, 4'b0000, 2'd2, 1'b1, 4'b0000);
        // Hold ch2, stall, reset during the stall, then the search restarts at channel 0.
        add(0, 1, 4'b0100, 2'd0, 1'b1, 4'b0100);
        add(0, 1, 4'b1111, 2'd0, 1'b0, 4'b0000);
        add(1, 1, 4'b0000, 2'd0, 1'b0, 4'b0000);
        add(0, 1, 4'b1110, 2'd0, 1'b1, 4'b0010);
        // Select mode, 3 channels: sel = 3 is out of range and drains the register.
        add(1, 2, 4'b0000, 2'd0, 1'b0, 4'b0000);
        add(0, 2, 4'b1111, 2'd0, 1'b0, 4'b0001);
        add(0, 2, 4'b1111, 2'd3, 1'b1, 4'b0000);
        add(0, 2, 4'b0111, 2'd3, 1'b1, 4'b0000);
        add(0, 2, 4'b0100, 2'd2, 1'b1, 4'b0100);

        rst_n = 1'b0; in_valid = '0; sel = '0; out_ready = 1'b0; in_data = '0;
        last = '0;
        @(posedge clk); #1;

        // Known word on ch2, sel = 2, all valid: one-cycle latency and steady in_ready.
        do_reset(0);
        randomize_data();
        in_data[64 +: 32] = 32'hDEAD_BEEF;
        cycle(0, 4'b1111, 2'd2, 1'b1, 4'b0100);
        sample(0, rdy, ov, od, oc);
        check("deadbeef_data", od, 32'hDEAD_BEEF);
        check("deadbeef_ch", oc, 2'd2);
        cycle(0, 4'b1111, 2'd2, 1'b1, 4'b0100);
        cycle(0, 4'b1111, 2'd2, 1'b1, 4'b0100);

        // Word 0x5 held through three stalled cycles with toggling inputs.
        cycle(0, 4'b0000, 2'd0, 1'b1, 4'b0001);
        in_data[32 +: 32] = 32'h5;
        cycle(0, 4'b0010, 2'd1, 1'b1, 4'b0010);
        for (int k = 0; k < 3; k++) begin
            randomize_data();
            cycle(0, 4'($urandom_range(0, 15)), 2'($urandom_range(0, 3)), 1'b0, 4'b0000);
            sample(0, rdy, ov, od, oc);
            check("stall_data", od, 32'h5);
            check("stall_valid", ov, 1'b1);
        end
        randomize_data();
        cycle(0, 4'b0001, 2'd0, 1'b1, 4'b0001);

        foreach (tbl[i]) begin
            if (tbl[i].rst) begin
                do_reset(tbl[i].d);
            end else begin
                randomize_data();
                cycle(tbl[i].d, tbl[i].v, tbl[i].s, tbl[i].ordy, tbl[i].rdy);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
